// File: rtl/qm_pkg.sv
// qm_pkg: shared opcode/funct constants and decode helpers
// for the qm pipelined decode stage.
package qm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  function automatic int qm_aw(input int nregs);
    return (nregs > 2) ? $clog2(nregs) : 1;
  endfunction

  // Opcodes whose rt field is a source operand.
  function automatic logic rt_is_src(
    input logic [5:0] op
  );
    return op inside {
      OP_RTYPE, OP_BEQ, OP_BNE,
      OP_SB, OP_SH, OP_SW
    };
  endfunction

endpackage

// File: rtl/qm_regfile_p.sv
// qm_regfile_p: 2R/1W register file, r0 hardwired to zero,
// same-cycle write-through on both read ports.
module qm_regfile_p #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra0,
  input  logic [AW-1:0]     ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd0 = regs[ra0];
    if (ra0 == '0)
      rd0 = '0;
    else if (we && wa == ra0)
      rd0 = wd;
  end

  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == '0)
      rd1 = '0;
    else if (we && wa == ra1)
      rd1 = wd;
  end

endmodule

// File: rtl/qm_decode_pipe.sv
// qm_decode_pipe: decode + operand read with forwarding,
// load-use stall and a registered ID/EX valid/ready stage.
module qm_decode_pipe
  import qm_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 32,
  parameter int CTRL_W  = 8,
  parameter bit FORWARD = 1'b1,
  localparam int AW     = qm_aw(NREGS)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              di_valid,
  output logic              di_ready,
  input  logic [31:0]       di_IR,
  output logic [5:0]        o_Opcode,
  output logic [5:0]        o_Function,
  input  logic [CTRL_W-1:0] ci_Ctrl,
  input  logic              ci_ImmZero,
  input  logic              wb_WE,
  input  logic [AW-1:0]     wb_WA,
  input  logic [DATA_W-1:0] wb_WD,
  input  logic              fw_WE,
  input  logic [AW-1:0]     fw_WA,
  input  logic [DATA_W-1:0] fw_WD,
  input  logic              ex_MemRead,
  input  logic [AW-1:0]     ex_WA,
  input  logic              flush,
  output logic              do_valid,
  input  logic              do_ready,
  output logic [DATA_W-1:0] do_RSVal,
  output logic [DATA_W-1:0] do_RTVal,
  output logic [DATA_W-1:0] do_Imm,
  output logic [AW-1:0]     do_RS,
  output logic [AW-1:0]     do_RT,
  output logic [AW-1:0]     do_RD,
  output logic [CTRL_W-1:0] do_Ctrl
);

  logic [AW-1:0]     rs_idx;
  logic [AW-1:0]     rt_idx;
  logic [AW-1:0]     rd_idx;
  logic [DATA_W-1:0] rf_rs;
  logic [DATA_W-1:0] rf_rt;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm;
  logic              fwd_rs;
  logic              fwd_rt;
  logic              ld_rs;
  logic              ld_rt;
  logic              stall;
  logic              advance;

  assign o_Opcode   = di_IR[31:26];
  assign o_Function = di_IR[5:0];

  assign rs_idx = di_IR[21 +: AW];
  assign rt_idx = di_IR[16 +: AW];
  assign rd_idx = di_IR[11 +: AW];

  qm_regfile_p #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_rf (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .we    (wb_WE),
    .wa    (wb_WA),
    .wd    (wb_WD),
    .ra0   (rs_idx),
    .ra1   (rt_idx),
    .rd0   (rf_rs),
    .rd1   (rf_rt)
  );

  // Forward hits exclude r0 so the select cases stay disjoint.
  assign fwd_rs = FORWARD && fw_WE &&
                  fw_WA == rs_idx && rs_idx != '0;
  assign fwd_rt = FORWARD && fw_WE &&
                  fw_WA == rt_idx && rt_idx != '0;

  always_comb begin
    rs_val = '0;
    unique case (1'b1)
      (rs_idx == '0): rs_val = '0;
      fwd_rs:         rs_val = fw_WD;
      default:        rs_val = rf_rs;
    endcase
  end

  always_comb begin
    rt_val = '0;
    unique case (1'b1)
      (rt_idx == '0): rt_val = '0;
      fwd_rt:         rt_val = fw_WD;
      default:        rt_val = rf_rt;
    endcase
  end

  always_comb begin
    imm = {{(DATA_W-16){di_IR[15]}}, di_IR[15:0]};
    if (ci_ImmZero)
      imm = {{(DATA_W-16){1'b0}}, di_IR[15:0]};
  end

  assign ld_rs = (ex_WA == rs_idx);
  assign ld_rt = rt_is_src(o_Opcode) &&
                 (ex_WA == rt_idx);
  assign stall = ex_MemRead && ex_WA != '0 &&
                 (ld_rs || ld_rt);

  assign advance  = !do_valid || do_ready;
  assign di_ready = sys_rst_n && advance &&
                    !stall && !flush;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      do_valid <= 1'b0;
      do_RSVal <= '0;
      do_RTVal <= '0;
      do_Imm   <= '0;
      do_RS    <= '0;
      do_RT    <= '0;
      do_RD    <= '0;
      do_Ctrl  <= '0;
    end else if (flush) begin
      do_valid <= 1'b0;
    end else if (advance) begin
      // A stall leaves di_ready low, so this inserts a bubble.
      do_valid <= di_valid && di_ready;
      do_RSVal <= rs_val;
      do_RTVal <= rt_val;
      do_Imm   <= imm;
      do_RS    <= rs_idx;
      do_RT    <= rt_idx;
      do_RD    <= rd_idx;
      do_Ctrl  <= ci_Ctrl;
    end
  end

endmodule

// File: tb/tb_qm_decode_pipe.sv
// tb_qm_decode_pipe: randomized and directed checks of
// qm_decode_pipe (FORWARD=1 and FORWARD=0) against a model.
module tb_qm_decode_pipe;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        di_valid;
  logic [31:0] di_IR;
  logic [7:0]  ci_Ctrl;
  logic        ci_ImmZero;
  logic        wb_WE;
  logic [4:0]  wb_WA;
  logic [31:0] wb_WD;
  logic        fw_WE;
  logic [4:0]  fw_WA;
  logic [31:0] fw_WD;
  logic        ex_MemRead;
  logic [4:0]  ex_WA;
  logic        flush;
  logic        do_ready;

  logic        di_ready, di_ready0;
  logic [5:0]  o_Opcode, o_Opcode0;
  logic [5:0]  o_Function, o_Function0;
  logic        do_valid, do_valid0;
  logic [31:0] do_RSVal, do_RSVal0;
  logic [31:0] do_RTVal, do_RTVal0;
  logic [31:0] do_Imm, do_Imm0;
  logic [4:0]  do_RS, do_RS0;
  logic [4:0]  do_RT, do_RT0;
  logic [4:0]  do_RD, do_RD0;
  logic [7:0]  do_Ctrl, do_Ctrl0;

  int n_tests;
  int n_fail;

  always #5 clk = ~clk;

  qm_decode_pipe #(.FORWARD(1'b1)) dut (
    .sys_clk(clk), .sys_rst_n(sys_rst_n),
    .di_valid(di_valid), .di_ready(di_ready),
    .di_IR(di_IR), .o_Opcode(o_Opcode),
    .o_Function(o_Function), .ci_Ctrl(ci_Ctrl),
    .ci_ImmZero(ci_ImmZero),
    .wb_WE(wb_WE), .wb_WA(wb_WA), .wb_WD(wb_WD),
    .fw_WE(fw_WE), .fw_WA(fw_WA), .fw_WD(fw_WD),
    .ex_MemRead(ex_MemRead), .ex_WA(ex_WA),
    .flush(flush), .do_valid(do_valid),
    .do_ready(do_ready), .do_RSVal(do_RSVal),
    .do_RTVal(do_RTVal), .do_Imm(do_Imm),
    .do_RS(do_RS), .do_RT(do_RT), .do_RD(do_RD),
    .do_Ctrl(do_Ctrl)
  );

  qm_decode_pipe #(.FORWARD(1'b0)) dut0 (
    .sys_clk(clk), .sys_rst_n(sys_rst_n),
    .di_valid(di_valid), .di_ready(di_ready0),
    .di_IR(di_IR), .o_Opcode(o_Opcode0),
    .o_Function(o_Function0), .ci_Ctrl(ci_Ctrl),
    .ci_ImmZero(ci_ImmZero),
    .wb_WE(wb_WE), .wb_WA(wb_WA), .wb_WD(wb_WD),
    .fw_WE(fw_WE), .fw_WA(fw_WA), .fw_WD(fw_WD),
    .ex_MemRead(ex_MemRead), .ex_WA(ex_WA),
    .flush(flush), .do_valid(do_valid0),
    .do_ready(do_ready), .do_RSVal(do_RSVal0),
    .do_RTVal(do_RTVal0), .do_Imm(do_Imm0),
    .do_RS(do_RS0), .do_RT(do_RT0), .do_RD(do_RD0),
    .do_Ctrl(do_Ctrl0)
  );

  // Reference model state: architectural regs and ID/EX contents.
  logic [31:0] m_rf [32];
  bit          m_valid;
  logic [31:0] m_rs1, m_rt1, m_rs0, m_rt0, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [7:0]  m_ctrl;

  function automatic logic [31:0] r_type(
    input int rs, input int rt, input int rd,
    input logic [5:0] fn
  );
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(
    input logic [5:0] op, input int rs, input int rt,
    input logic [15:0] imm
  );
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic bit m_reads_rt(input logic [5:0] op);
    return op == 6'h00 || op == 6'h04 || op == 6'h05 ||
           op == 6'h28 || op == 6'h29 || op == 6'h2B;
  endfunction

  function automatic logic [31:0] m_operand(
    input logic [4:0] idx, input bit fwd
  );
    if (idx == 0) return 32'h0;
    if (fwd && fw_WE && fw_WA == idx) return fw_WD;
    if (wb_WE && wb_WA == idx) return wb_WD;
    return m_rf[idx];
  endfunction

  function automatic logic [119:0] bundle1();
    return {do_valid, do_RSVal, do_RTVal, do_Imm,
            do_RS, do_RT, do_RD, do_Ctrl};
  endfunction

  function automatic logic [119:0] bundle0();
    return {do_valid0, do_RSVal0, do_RTVal0, do_Imm0,
            do_RS0, do_RT0, do_RD0, do_Ctrl0};
  endfunction

  // One clock: check handshake, advance model, compare ID/EX.
  task automatic tick();
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    bit          stall, adv, rdy;
    bit          rst, fl, dv, wbwe;
    logic [4:0]  wbwa;
    logic [31:0] wbwd, nrs1, nrt1, nrs0, nrt0, nimm;
    logic [7:0]  nctrl;
    logic [119:0] e1, e0;
    #1;
    op = di_IR[31:26];
    rs = di_IR[25:21];
    rt = di_IR[20:16];
    rd = di_IR[15:11];
    stall = ex_MemRead && ex_WA != 0 &&
            (ex_WA == rs || (m_reads_rt(op) && ex_WA == rt));
    adv = !m_valid || do_ready;
    rdy = sys_rst_n && adv && !stall && !flush;
    n_tests++;
    if (di_ready !== rdy || di_ready0 !== rdy) begin
      n_fail++;
      $display("FAIL di_ready got %b/%b want %b",
               di_ready, di_ready0, rdy);
    end
    n_tests++;
    if (o_Opcode !== op || o_Function !== di_IR[5:0]) begin
      n_fail++;
      $display("FAIL opfn got %h/%h want %h/%h",
               o_Opcode, o_Function, op, di_IR[5:0]);
    end
    nrs1 = m_operand(rs, 1'b1);
    nrt1 = m_operand(rt, 1'b1);
    nrs0 = m_operand(rs, 1'b0);
    nrt0 = m_operand(rt, 1'b0);
    nimm = ci_ImmZero ? 32'(di_IR[15:0])
                      : 32'($signed(di_IR[15:0]));
    nctrl = ci_Ctrl;
    rst = !sys_rst_n;
    fl = flush;
    dv = di_valid;
    wbwe = wb_WE;
    wbwa = wb_WA;
    wbwd = wb_WD;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_valid = 0;
      {m_rs1, m_rt1, m_rs0, m_rt0, m_imm} = '0;
      {m_rs, m_rt, m_rd, m_ctrl} = '0;
    end else begin
      if (wbwe && wbwa != 0) m_rf[wbwa] = wbwd;
      if (fl) begin
        m_valid = 0;
      end else if (adv) begin
        m_valid = dv && rdy;
        m_rs1 = nrs1; m_rt1 = nrt1;
        m_rs0 = nrs0; m_rt0 = nrt0;
        m_imm = nimm; m_ctrl = nctrl;
        m_rs = rs; m_rt = rt; m_rd = rd;
      end
    end
    e1 = {m_valid, m_rs1, m_rt1, m_imm, m_rs, m_rt, m_rd, m_ctrl};
    e0 = {m_valid, m_rs0, m_rt0, m_imm, m_rs, m_rt, m_rd, m_ctrl};
    n_tests++;
    if (bundle1() !== e1) begin
      n_fail++;
      $display("FAIL idex_fwd1 got %h want %h", bundle1(), e1);
    end
    n_tests++;
    if (bundle0() !== e0) begin
      n_fail++;
      $display("FAIL idex_fwd0 got %h want %h", bundle0(), e0);
    end
  endtask

  task automatic idle_inputs();
    di_valid = 1'b1;
    ci_Ctrl = 8'h00;
    ci_ImmZero = 1'b0;
    wb_WE = 1'b0; wb_WA = '0; wb_WD = '0;
    fw_WE = 1'b0; fw_WA = '0; fw_WD = '0;
    ex_MemRead = 1'b0; ex_WA = '0;
    flush = 1'b0;
    do_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    sys_rst_n = 1'b0;
    di_IR = r_type(1, 2, 3, 6'h20);
    #1;
    n_tests++;
    if (di_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 0", di_ready);
    end
    tick();
    tick();
    n_tests++;
    if (do_valid !== 1'b0 || do_RSVal !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out got %b/%h want 0/0",
               do_valid, do_RSVal);
    end
    sys_rst_n = 1'b1;
    tick();
    n_tests++;
    if (do_valid !== 1'b1 || do_RD !== 5'd3) begin
      n_fail++;
      $display("FAIL reset_release got %b/%0d want 1/3",
               do_valid, do_RD);
    end
  endtask

  task automatic test_write_through();
    idle_inputs();
    wb_WE = 1'b1; wb_WA = 5'd5; wb_WD = 32'hDEADBEEF;
    di_IR = r_type(5, 0, 3, 6'h20);
    tick();
    n_tests++;
    if (do_RSVal !== 32'hDEADBEEF || do_RTVal !== 32'h0) begin
      n_fail++;
      $display("FAIL wt_read got %h/%h want deadbeef/0",
               do_RSVal, do_RTVal);
    end
    wb_WA = 5'd0; wb_WD = 32'h1234;
    di_IR = r_type(0, 0, 3, 6'h20);
    tick();
    n_tests++;
    if (do_RSVal !== 32'h0) begin
      n_fail++;
      $display("FAIL wt_r0 got %h want 0", do_RSVal);
    end
    wb_WE = 1'b0;
    di_IR = r_type(0, 5, 4, 6'h22);
    tick();
    n_tests++;
    if (do_RSVal !== 32'h0 || do_RTVal !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wt_persist got %h/%h want 0/deadbeef",
               do_RSVal, do_RTVal);
    end
  endtask

  task automatic test_forward_priority();
    idle_inputs();
    fw_WE = 1'b1; fw_WA = 5'd7; fw_WD = 32'h11;
    wb_WE = 1'b1; wb_WA = 5'd7; wb_WD = 32'h22;
    di_IR = r_type(7, 0, 1, 6'h20);
    tick();
    n_tests++;
    if (do_RSVal !== 32'h11 || do_RSVal0 !== 32'h22) begin
      n_fail++;
      $display("FAIL fwd_prio got %h/%h want 11/22",
               do_RSVal, do_RSVal0);
    end
    fw_WA = 5'd0; fw_WD = 32'h55;
    wb_WE = 1'b0;
    di_IR = r_type(0, 7, 1, 6'h20);
    tick();
    n_tests++;
    if (do_RSVal !== 32'h0 || do_RTVal !== 32'h22) begin
      n_fail++;
      $display("FAIL fwd_r0 got %h/%h want 0/22",
               do_RSVal, do_RTVal);
    end
    fw_WE = 1'b0;
  endtask

  task automatic test_load_use();
    idle_inputs();
    ex_MemRead = 1'b1; ex_WA = 5'd4;
    di_IR = r_type(4, 1, 2, 6'h20);
    #1;
    n_tests++;
    if (di_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_stall got %b want 0", di_ready);
    end
    tick();
    n_tests++;
    if (do_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_bubble got %b want 0", do_valid);
    end
    di_IR = i_type(6'h23, 1, 4, 16'h0010);
    #1;
    n_tests++;
    if (di_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_lw_rt got %b want 1", di_ready);
    end
    di_IR = i_type(6'h2B, 1, 4, 16'h0010);
    #1;
    n_tests++;
    if (di_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_sw_rt got %b want 0", di_ready);
    end
    tick();
    ex_MemRead = 1'b0;
    di_IR = r_type(4, 1, 2, 6'h20);
    tick();
    n_tests++;
    if (do_valid !== 1'b1 || do_RS !== 5'd4) begin
      n_fail++;
      $display("FAIL lu_resume got %b/%0d want 1/4",
               do_valid, do_RS);
    end
    ex_MemRead = 1'b1; ex_WA = 5'd0;
    di_IR = r_type(0, 0, 2, 6'h20);
    #1;
    n_tests++;
    if (di_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_r0 got %b want 1", di_ready);
    end
    tick();
    ex_MemRead = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [119:0] snap;
    idle_inputs();
    di_IR = r_type(1, 2, 3, 6'h20);
    tick();
    do_ready = 1'b0;
    di_IR = r_type(2, 3, 9, 6'h24);
    snap = bundle1();
    repeat (3) begin
      #1;
      n_tests++;
      if (di_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready got %b want 0", di_ready);
      end
      tick();
      n_tests++;
      if (bundle1() !== snap) begin
        n_fail++;
        $display("FAIL bp_hold got %h want %h", bundle1(), snap);
      end
    end
    do_ready = 1'b1;
    tick();
    n_tests++;
    if (do_valid !== 1'b1 || do_RD !== 5'd9) begin
      n_fail++;
      $display("FAIL bp_release got %b/%0d want 1/9",
               do_valid, do_RD);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    di_IR = r_type(1, 2, 6, 6'h25);
    tick();
    do_ready = 1'b0;
    flush = 1'b1;
    #1;
    n_tests++;
    if (di_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_ready got %b want 0", di_ready);
    end
    tick();
    n_tests++;
    if (do_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_kill got %b want 0", do_valid);
    end
    do_ready = 1'b1;
    ex_MemRead = 1'b1; ex_WA = 5'd1;
    di_IR = r_type(1, 2, 6, 6'h25);
    tick();
    n_tests++;
    if (do_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_stall got %b want 0", do_valid);
    end
    flush = 1'b0;
    ex_MemRead = 1'b0;
    tick();
    n_tests++;
    if (do_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_resume got %b want 1", do_valid);
    end
  endtask

  task automatic test_immediate();
    idle_inputs();
    di_IR = i_type(6'h08, 1, 2, 16'h8000);
    tick();
    n_tests++;
    if (do_Imm !== 32'hFFFF8000) begin
      n_fail++;
      $display("FAIL imm_sext got %h want ffff8000", do_Imm);
    end
    ci_ImmZero = 1'b1;
    tick();
    n_tests++;
    if (do_Imm !== 32'h00008000) begin
      n_fail++;
      $display("FAIL imm_zext got %h want 00008000", do_Imm);
    end
    ci_ImmZero = 1'b0;
    di_IR = i_type(6'h0D, 1, 2, 16'h7FFF);
    tick();
    n_tests++;
    if (do_Imm !== 32'h00007FFF) begin
      n_fail++;
      $display("FAIL imm_pos got %h want 00007fff", do_Imm);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h04, 6'h05, 6'h08,
            6'h23, 6'h2B, 6'h28, 6'h0D};
    for (int n = 0; n < 400; n++) begin
      sys_rst_n = ($urandom_range(0, 99) != 0);
      di_valid = ($urandom_range(0, 3) != 0);
      do_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      ex_MemRead = ($urandom_range(0, 3) == 0);
      ex_WA = 5'($urandom_range(0, 7));
      wb_WE = $urandom_range(0, 1);
      wb_WA = 5'($urandom_range(0, 7));
      wb_WD = $urandom;
      fw_WE = $urandom_range(0, 1);
      fw_WA = 5'($urandom_range(0, 7));
      fw_WD = $urandom;
      ci_Ctrl = 8'($urandom);
      ci_ImmZero = $urandom_range(0, 1);
      di_IR = $urandom;
      di_IR[31:26] = ops[$urandom_range(0, 7)];
      di_IR[25:21] = 5'($urandom_range(0, 7));
      di_IR[20:16] = 5'($urandom_range(0, 7));
      tick();
    end
    sys_rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    m_valid = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    {m_rs1, m_rt1, m_rs0, m_rt0, m_imm} = '0;
    {m_rs, m_rt, m_rd, m_ctrl} = '0;
    sys_rst_n = 1'b0;
    di_IR = '0;
    idle_inputs();
    test_reset();
    test_write_through();
    test_forward_priority();
    test_load_use();
    test_backpressure();
    test_flush();
    test_immediate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
